// File: rtl/scurve_step_gen.sv
// scurve_step_gen: step-rate word -> STEP/DIR pulse train for an external
// stepper driver.
//
// A phase accumulator (NCO) adds the latched 16-bit rate word every enabled
// cycle. Each carry out of the accumulator is one step request. A pulse FSM
// turns requests into STEP pulses. Each pulse is high for PULSE_W clocks and
// is followed by at least PULSE_W low clocks. When the requested direction
// differs from the driven DIR level, DIR is changed first and held for
// DIR_SETUP clocks before the STEP rising edge.
//
// One request can wait in a pending slot while a pulse is in progress. A
// further request that arrives while the slot is still full is dropped, and
// this sets the sticky o_overrun flag.
//
// Optional feature macro: STEP_POSITION_EN
//   defined   : o_position is a 32-bit signed up/down step counter that
//               wraps in two's complement.
//   undefined : o_position is tied to 0 and has no flops.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_rate         : unsigned step-rate word
//   i_rate_valid   : one-cycle strobe; latches i_rate and i_dir
//   i_dir          : requested direction, 1 = forward
//   i_enable       : accumulator run enable
//   o_step, o_dir  : driver pins
//   o_busy         : pulse in progress or step pending
//   o_overrun      : sticky, a step request was lost
//   o_position     : signed step position (feature dependent)
module scurve_step_gen #(
  parameter int ACC_W     = 24,
  parameter int PULSE_W   = 4,
  parameter int DIR_SETUP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_rate,
  input  logic        i_rate_valid,
  input  logic        i_dir,
  input  logic        i_enable,
  output logic        o_step,
  output logic        o_dir,
  output logic        o_busy,
  output logic        o_overrun,
  output logic [31:0] o_position
);

  // The counter only has to hold "length - 1" of the longest timed state.
  localparam int CNT_MAX = (PULSE_W > DIR_SETUP) ? PULSE_W : DIR_SETUP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] DS_LAST = CNT_W'(DIR_SETUP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    HIGH  = 2'b10,
    LOW   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic [15:0]        rate_q, rate_d;
  logic               dir_req_q, dir_req_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               pend_q, pend_d;
  logic               ovr_q, ovr_d;

  logic [ACC_W:0]     sum;
  logic               carry;
  logic               req;
  logic               take;

  // ---------------------------------------------------------------------
  // Rate latch and phase accumulator
  // ---------------------------------------------------------------------
  always_comb begin
    rate_d    = rate_q;
    dir_req_d = dir_req_q;
    if (i_rate_valid) begin
      rate_d    = i_rate;
      dir_req_d = i_dir;
    end
    // A rate strobe in the same cycle as a carry does not affect that carry,
    // because the sum always uses the previously latched rate.
    sum   = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, rate_q};
    carry = i_enable & sum[ACC_W];
    acc_d = i_enable ? sum[ACC_W-1:0] : acc_q;
  end

  // ---------------------------------------------------------------------
  // Pending slot and overrun
  // ---------------------------------------------------------------------
  assign req  = carry | pend_q;
  assign take = (state_q == IDLE) & req;

  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (take && pend_q) begin
      // The pending step is served now. A carry in the same cycle takes the
      // slot that has just been freed.
      pend_d = carry;
    end else if (carry && !take) begin
      if (pend_q) ovr_d = 1'b1;
      pend_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Pulse FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  // ---------------------------------------------------------------------
  // Pulse FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (dir_req_q == dir_q) begin
            state_d = HIGH;
            cnt_d   = PW_LAST;
          end else begin
            // DIR is only ever changed here, so it is stable through
            // SETUP, HIGH and LOW.
            dir_d   = dir_req_q;
            state_d = SETUP;
            cnt_d   = DS_LAST;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = PW_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = PW_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pulse FSM: outputs
  // ---------------------------------------------------------------------
  // STEP is registered so that a multi-bit state change cannot cause a
  // glitch on the driver pin.
  always_comb begin
    step_d = (state_d == HIGH);
    o_busy = (state_q != IDLE) | pend_q;
  end

  assign o_step    = step_q;
  assign o_dir     = dir_q;
  assign o_overrun = ovr_q;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rate_q    <= '0;
      dir_req_q <= 1'b1;
      acc_q     <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rate_q    <= rate_d;
      dir_req_q <= dir_req_d;
      acc_q     <= acc_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Step position counter
  // ---------------------------------------------------------------------
`ifdef STEP_POSITION_EN
  logic [31:0] pos_q, pos_d;
  logic        hi_entry;

  always_comb begin
    hi_entry = (state_d == HIGH) && (state_q != HIGH);
    pos_d    = pos_q;
    // On entry to HIGH, dir_q already holds the direction of this step.
    if (hi_entry) pos_d = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pos_q <= '0;
    else          pos_q <= pos_d;
  end

  assign o_position = pos_q;
`else
  assign o_position = '0;
`endif

endmodule

// File: tb/tb_scurve_step_gen.sv
module tb_scurve_step_gen;
  localparam int PW = 4;
  localparam int DS = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_rate = '0;
  logic        i_rate_valid = 1'b0;
  logic        i_dir = 1'b1;
  logic        i_enable = 1'b0;
  logic [1:0]  step_w, dir_w, busy_w, ovr_w;
  logic [31:0] pos_w [2];

  always #5 i_clk = ~i_clk;

  // Instance 0 uses the default 24-bit accumulator. Instance 1 uses a 17-bit
  // accumulator to reach the maximum step rate and the overrun case.
  scurve_step_gen #(.ACC_W(24), .PULSE_W(PW), .DIR_SETUP(DS)) u_dut24 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rate(i_rate), .i_rate_valid(i_rate_valid),
    .i_dir(i_dir), .i_enable(i_enable), .o_step(step_w[0]), .o_dir(dir_w[0]),
    .o_busy(busy_w[0]), .o_overrun(ovr_w[0]), .o_position(pos_w[0]));

  scurve_step_gen #(.ACC_W(17), .PULSE_W(PW), .DIR_SETUP(DS)) u_dut17 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rate(i_rate), .i_rate_valid(i_rate_valid),
    .i_dir(i_dir), .i_enable(i_enable), .o_step(step_w[1]), .o_dir(dir_w[1]),
    .o_busy(busy_w[1]), .o_overrun(ovr_w[1]), .o_position(pos_w[1]));

  typedef struct {
    longint edge_n;
    bit     dir;
    int     pos;
  } rise_t;

  rise_t  q0[$], q1[$];
  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model, evaluated once per clock edge.
  // Step requests come from integer phase arithmetic. Pulse timing is
  // handled as absolute edge numbers: the edge of the next rise and the
  // first edge at which the generator can accept a new request.
  // ------------------------------------------------------------------
  longint m_acc [2];
  int     m_rate [2];
  bit     m_rdir [2], m_dir [2], m_pend [2], m_ovr [2];
  longint m_idle [2], m_hi [2];
  int     m_pos [2], m_npos [2];

  function automatic longint modv(int k);
    return (k == 0) ? (64'sd1 <<< 24) : (64'sd1 <<< 17);
  endfunction

  always @(posedge i_clk) begin
    longint s;
    bit     c, take;
    rise_t  e;
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!i_rst_n) begin
        m_acc[k] = 0; m_rate[k] = 0; m_rdir[k] = 1; m_dir[k] = 1;
        m_pend[k] = 0; m_ovr[k] = 0; m_idle[k] = 0; m_hi[k] = -1000;
        m_pos[k] = 0; m_npos[k] = 0;
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        c = 0;
        if (i_enable) begin
          s = m_acc[k] + longint'(m_rate[k]);
          c = (s >= modv(k));
          m_acc[k] = s % modv(k);
        end
        take = (cyc >= m_idle[k]) && (m_pend[k] || c);
        if (take && m_pend[k]) m_pend[k] = c;
        else if (c && !take) begin
          if (m_pend[k]) m_ovr[k] = 1;
          m_pend[k] = 1;
        end
        if (take) begin
          if (m_rdir[k] != m_dir[k]) begin
            m_dir[k] = m_rdir[k];
            m_hi[k]  = cyc + DS;
          end else begin
            m_hi[k] = cyc;
          end
          m_idle[k] = m_hi[k] + 2*PW + 1;
`ifdef STEP_POSITION_EN
          m_npos[k] = m_pos[k] + (m_dir[k] ? 1 : -1);
`else
          m_npos[k] = 0;
`endif
          e.edge_n = m_hi[k]; e.dir = m_dir[k]; e.pos = m_npos[k];
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (cyc == m_hi[k]) m_pos[k] = m_npos[k];
        if (i_rate_valid) begin
          m_rate[k] = int'(i_rate);
          m_rdir[k] = i_dir;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Monitor: per-cycle level checks, plus a scoreboard pop on each rise.
  // ------------------------------------------------------------------
  bit prev [2];
  int wid [2];

  always @(negedge i_clk) begin
    rise_t r;
    bit    have;
    for (int k = 0; k < 2; k++) begin
      if (!i_rst_n) begin
        prev[k] = 0; wid[k] = 0;
      end else begin
        chk($sformatf("step[%0d]", k), step_w[k], (cyc >= m_hi[k]) && (cyc < m_hi[k] + PW));
        chk($sformatf("dir[%0d]", k), dir_w[k], m_dir[k]);
        chk($sformatf("busy[%0d]", k), busy_w[k], (cyc + 1 < m_idle[k]) || m_pend[k]);
        chk($sformatf("overrun[%0d]", k), ovr_w[k], m_ovr[k]);
        chk($sformatf("position[%0d]", k), longint'($signed(pos_w[k])), m_pos[k]);
        if (step_w[k] && !prev[k]) begin
          have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!have) begin
            n_checks++; n_fail++;
            $display("FAIL rise[%0d]: unexpected STEP rise at edge %0d, expected none", k, cyc);
          end else begin
            r = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rise_edge[%0d]", k), cyc, r.edge_n);
            chk($sformatf("rise_dir[%0d]", k), dir_w[k], r.dir);
            chk($sformatf("rise_pos[%0d]", k), longint'($signed(pos_w[k])), r.pos);
          end
          wid[k] = 0;
        end
        if (step_w[k]) wid[k]++;
        if (!step_w[k] && prev[k]) chk($sformatf("high_width[%0d]", k), wid[k], PW);
        prev[k] = step_w[k];
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic run(int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic strobe(logic [15:0] rate, logic dir);
    @(negedge i_clk);
    i_rate = rate; i_dir = dir; i_rate_valid = 1'b1;
    @(negedge i_clk);
    i_rate_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_step[%0d]", tag, k), step_w[k], 0);
      chk($sformatf("%s_dir[%0d]", tag, k), dir_w[k], 1);
      chk($sformatf("%s_busy[%0d]", tag, k), busy_w[k], 0);
      chk($sformatf("%s_overrun[%0d]", tag, k), ovr_w[k], 0);
      chk($sformatf("%s_position[%0d]", tag, k), pos_w[k], 0);
    end
  endtask

  task automatic wait_rise0(int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge i_clk);
      seen = step_w[0];
    end
    chk("wait_rise_timeout", seen, 1);
  endtask

  initial begin
    run(3);
    chk_reset_vals("reset");
    #2 i_rst_n = 1'b1;

    // Slow forward stepping: period 4096 on the 24-bit instance.
    i_enable = 1'b1;
    strobe(16'h1000, 1'b1);
    run(4 * 4096 + 300);

    // Rate 0: the in-flight pulse completes, then the outputs stay quiet.
    strobe(16'h0000, 1'b1);
    run(10000);
    chk("idle_busy0", busy_w[0], 0);
    chk("idle_busy1", busy_w[1], 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    // Forward at 0x8000, then reverse: DIR setup before the next step.
    strobe(16'h8000, 1'b1);
    run(2000);
    strobe(16'h8000, 1'b0);
    run(3000);

    // Full rate: back-to-back steps and overrun on the 17-bit instance.
    strobe(16'hFFFF, 1'b1);
    run(200);
    chk("overrun_set17", ovr_w[1], 1);

    // Drop enable two clocks into a pulse, hold, then re-enable.
    strobe(16'h8000, 1'b1);
    wait_rise0(2000);
    run(2);
    i_enable = 1'b0;
    run(300);
    i_enable = 1'b1;
    run(1500);

    // Random phase.
    for (int i = 0; i < 25; i++) begin
      @(negedge i_clk);
      i_enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) strobe(16'h0000, 1'($urandom_range(0, 1)));
      else strobe(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      run($urandom_range(20, 600));
    end

    // Reset one clock into a pulse.
    i_enable = 1'b1;
    strobe(16'hFFFF, 1'b1);
    wait_rise0(2000);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    run(3);
    #2 i_rst_n = 1'b1;
    run(100);
    chk("post_reset_step0", step_w[0], 0);
    chk("post_reset_q0", q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
